// File: rtl/phy_pkg.sv
// ============================================================================
// Module : phy_pkg
// Brief  : Line-code characters and receive FSM encoding shared by the TX/RX
//          serial PHY stages.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package phy_pkg;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    function automatic logic is_fill(input logic [7:0] b);
        return (b == COM) || (b == IDLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sp_shift8.sv
// ============================================================================
// Module : sp_shift8
// Brief  : Serial bit shifter with a byte-phase counter; exposes the candidate
//          byte formed with the bit currently on the line.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_shift8 (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       realign,
    output logic [7:0] next_byte,
    output logic       boundary
);

    // Only the seven most recent bits are kept; the eighth is the live input.
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt;

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_sr      <= 7'd0;
            r_bit_cnt <= 3'd0;
        end else begin
            r_sr      <= {r_sr[5:0], data_in};
            r_bit_cnt <= realign ? 3'd0 : r_bit_cnt + 3'd1;
        end
    end

    assign next_byte = {r_sr, data_in};
    assign boundary  = (r_bit_cnt == 3'd7);

endmodule

`default_nettype wire

// File: rtl/recibidor_sp_rx.sv
// ============================================================================
// Module : recibidor_sp_rx
// Brief  : Serial-to-parallel receiver: COM-based byte alignment, lock
//          detection and payload delivery with fill stripping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module recibidor_sp_rx
    import phy_pkg::*;
#(
    parameter int LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out_sp,
    output logic       valid_out_sp,
    output logic       active_out
);

    localparam logic [3:0] c_lock = 4'(LOCK_COUNT);

    rx_state_t  r_state;
    logic [3:0] r_com_cnt;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_active;

    logic [7:0] w_nb;
    logic       w_boundary;
    logic       w_realign;
    logic [3:0] w_com_next;

    // Any COM seen while hunting defines the new byte phase.
    assign w_realign  = (r_state == SEARCH) && (w_nb == COM);
    assign w_com_next = r_com_cnt + 4'd1;

    sp_shift8 u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .realign   (w_realign),
        .next_byte (w_nb),
        .boundary  (w_boundary)
    );

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            r_state   <= SEARCH;
            r_com_cnt <= 4'd0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            case (r_state)
                SEARCH: begin
                    if (w_nb == COM) begin
                        r_com_cnt <= 4'd1;
                        if (c_lock == 4'd1) begin
                            r_state  <= ACTIVE;
                            r_active <= 1'b1;
                            r_data   <= w_nb;
                            r_valid  <= 1'b0;
                        end else begin
                            r_state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    if (w_boundary) begin
                        if (w_nb == COM) begin
                            if (w_com_next >= c_lock) begin
                                r_state   <= ACTIVE;
                                r_active  <= 1'b1;
                                r_com_cnt <= c_lock;
                                r_data    <= w_nb;
                                r_valid   <= 1'b0;
                            end else begin
                                r_com_cnt <= w_com_next;
                            end
                        end else begin
                            r_state   <= SEARCH;
                            r_com_cnt <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    // Lock is sticky; only reset leaves this state.
                    if (w_boundary) begin
                        r_data  <= w_nb;
                        r_valid <= !is_fill(w_nb);
                    end
                end
                default: begin
                    r_state <= SEARCH;
                end
            endcase
        end
    end

    assign data_out_sp  = r_data;
    assign valid_out_sp = r_valid;
    assign active_out   = r_active;

endmodule

`default_nettype wire

// File: tb/tb_recibidor_sp_rx.sv
// ============================================================================
// Module : tb_recibidor_sp_rx
// Brief  : Self-checking bench for recibidor_sp_rx (table + scoreboard).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_recibidor_sp_rx;
    import phy_pkg::*;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out_sp;
    logic       valid_out_sp;
    logic       active_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] data;
        logic       valid;
    } vec_t;

    exp_t exp_q[$];
    exp_t last_exp;
    bit   hold_chk = 1'b0;
    vec_t tbl[8];

    recibidor_sp_rx #(.LOCK_COUNT(4)) dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .data_in      (data_in),
        .data_out_sp  (data_out_sp),
        .valid_out_sp (valid_out_sp),
        .active_out   (active_out)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (hold_chk && i == 4) begin
                check8("hold_data", data_out_sp, last_exp.data);
                check1("hold_valid", valid_out_sp, last_exp.valid);
            end
        end
    endtask

    task automatic sb_byte(input logic [7:0] b, input logic [7:0] ed, input logic ev);
        exp_t e;
        e.data  = ed;
        e.valid = ev;
        exp_q.push_back(e);
        send_byte(b);
        e = exp_q.pop_front();
        check8("byte_data", data_out_sp, e.data);
        check1("byte_valid", valid_out_sp, e.valid);
        last_exp = e;
        hold_chk = 1'b1;
    endtask

    task automatic do_reset(input int cycles);
        hold_chk = 1'b0;
        reset = 1'b0;
        repeat (cycles) send_bit(1'($urandom_range(0, 1)));
        reset = 1'b1;
    endtask

    task automatic lock4(input string tag);
        repeat (3) send_byte(COM);
        check1({tag, "_active_pre"}, active_out, 1'b0);
        check8({tag, "_data_pre"}, data_out_sp, 8'h00);
        for (int i = 7; i >= 1; i--) send_bit(COM[i]);
        check1({tag, "_active_31"}, active_out, 1'b0);
        send_bit(COM[0]);
        check1({tag, "_active_32"}, active_out, 1'b1);
        check8({tag, "_data_lock"}, data_out_sp, COM);
        check1({tag, "_valid_lock"}, valid_out_sp, 1'b0);
    endtask

    initial begin
        logic [31:0] words [2];
        logic [7:0]  w_b;

        tbl[0] = '{8'hA5, 8'hA5, 1'b1};
        tbl[1] = '{8'h3C, 8'h3C, 1'b1};
        tbl[2] = '{8'h7C, 8'h7C, 1'b0};
        tbl[3] = '{8'hFF, 8'hFF, 1'b1};
        tbl[4] = '{8'hBC, 8'hBC, 1'b0};
        tbl[5] = '{8'h0B, 8'h0B, 1'b1};   // 0B C0 hides an unaligned COM
        tbl[6] = '{8'hC0, 8'hC0, 1'b1};
        tbl[7] = '{8'h00, 8'h00, 1'b1};

        // Reset with random line activity
        hold_chk = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            check1("rst_active", active_out, 1'b0);
        end
        check8("rst_data", data_out_sp, 8'h00);
        check1("rst_valid", valid_out_sp, 1'b0);
        reset = 1'b1;

        // Lock and payload table
        lock4("lock");
        for (int i = 0; i < 8; i++) sb_byte(tbl[i].din, tbl[i].data, tbl[i].valid);

        // Misalignment: broken COM run must restart the hunt
        do_reset(2);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h12);
        check1("mis_active_after12", active_out, 1'b0);
        lock4("relock");
        sb_byte(8'h33, 8'h33, 1'b1);

        // Reset asserted on bit 4 of 0x5A
        hold_chk = 1'b0;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        reset = 1'b0;
        send_bit(1'b1);
        check8("mid_rst_data", data_out_sp, 8'h00);
        check1("mid_rst_valid", valid_out_sp, 1'b0);
        check1("mid_rst_active", active_out, 1'b0);
        reset = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        lock4("post_rst");

        // Loopback of 32-bit words serialized MSB byte / MSB bit first
        words[0] = 32'hDEADBEEF;
        words[1] = 32'h01020304;
        for (int w = 0; w < 2; w++) begin
            for (int k = 3; k >= 0; k--) begin
                w_b = words[w][8*k +: 8];
                sb_byte(w_b, w_b, !((w_b == COM) || (w_b == IDLE)));
            end
        end

        check1("final_active", active_out, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
